// File: rtl/btn_event_controller.sv
// -----------------------------------------------------------------------------
// btn_event_controller
//
// Shared debounce and event scheduler for the board push-buttons. A single
// prescaler tick paces one debouncer per button. Each debounced button emits
// PRESS, RELEASE, LONG and REPEAT events into a one-deep pending slot; a
// round-robin arbiter drains the slots onto a single valid/ready event port.
//
// Ports
//   i_clk        system clock
//   i_reset_n    synchronous reset, active-low
//   i_btn        raw asynchronous button inputs, active-high
//   o_evt_valid  an event is presented on o_evt_btn / o_evt_type
//   i_evt_ready  consumer takes the event when valid && ready at a clock edge
//   o_evt_btn    index of the button that produced the event
//   o_evt_type   00 PRESS, 01 RELEASE, 10 LONG, 11 REPEAT
//   o_btn_level  debounced button levels
//   o_overflow   sticky flag: an event was dropped (cleared only by reset)
// -----------------------------------------------------------------------------
module btn_event_controller #(
    parameter int N_BTN        = 4,
    parameter int TICK_DIV     = 100000,
    parameter int STABLE_TICKS = 4,
    parameter int LONG_TICKS   = 500,
    parameter int REPEAT_TICKS = 100
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic [N_BTN-1:0]         i_btn,
    output logic                     o_evt_valid,
    input  logic                     i_evt_ready,
    output logic [$clog2(N_BTN)-1:0] o_evt_btn,
    output logic [1:0]               o_evt_type,
    output logic [N_BTN-1:0]         o_btn_level,
    output logic                     o_overflow
);

    localparam int BW = $clog2(N_BTN);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = $clog2(STABLE_TICKS) + 1;
    localparam int HW = $clog2(LONG_TICKS + REPEAT_TICKS) + 1;
    localparam int RW = $clog2(REPEAT_TICKS) + 1;

    typedef enum logic [1:0] {
        EVT_PRESS   = 2'b00,
        EVT_RELEASE = 2'b01,
        EVT_LONG    = 2'b10,
        EVT_REPEAT  = 2'b11
    } evt_type_e;

    // Index of the button 'offs' positions after 'base', wrapping at N_BTN.
    function automatic logic [BW-1:0] rr_idx(input logic [BW-1:0] base, input int offs);
        int sum_v;
        sum_v = int'(base) + offs;
        if (sum_v >= N_BTN) begin
            sum_v = sum_v - N_BTN;
        end else begin
            sum_v = sum_v;
        end
        return BW'(sum_v);
    endfunction

    // State registers and their next-state values
    logic [PW-1:0]    presc_q, presc_d;
    logic [N_BTN-1:0] sync1_q, sync1_d;
    logic [N_BTN-1:0] sync2_q, sync2_d;
    logic [N_BTN-1:0] level_q, level_d;
    logic [SW-1:0]    stab_q [N_BTN];
    logic [SW-1:0]    stab_d [N_BTN];
    logic [HW-1:0]    hold_q [N_BTN];
    logic [HW-1:0]    hold_d [N_BTN];
    logic [RW-1:0]    rep_q  [N_BTN];
    logic [RW-1:0]    rep_d  [N_BTN];
    logic [N_BTN-1:0] slot_v_q, slot_v_d;
    logic [1:0]       slot_t_q [N_BTN];
    logic [1:0]       slot_t_d [N_BTN];
    logic [BW-1:0]    ptr_q, ptr_d;
    logic             evt_valid_q, evt_valid_d;
    logic [BW-1:0]    evt_btn_q, evt_btn_d;
    logic [1:0]       evt_type_q, evt_type_d;
    logic             overflow_q, overflow_d;

    // Combinational helpers
    logic             tick_s;
    logic [N_BTN-1:0] post_s;
    logic [1:0]       post_type_s [N_BTN];
    logic             load_s;
    logic             win_found_s;
    logic [BW-1:0]    win_idx_s;
    logic [N_BTN-1:0] grant_s;

    assign tick_s = (presc_q == PW'(TICK_DIV - 1));
    assign load_s = !evt_valid_q || i_evt_ready;

    // Prescaler wrap and two-flop input synchroniser
    always_comb begin
        sync1_d = i_btn;
        sync2_d = sync1_q;
        if (tick_s) begin
            presc_d = {PW{1'b0}};
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

    // Per-button debounce, hold timer and event posting (tick cycles only)
    always_comb begin
        for (int b = 0; b < N_BTN; b++) begin
            level_d[b]     = level_q[b];
            stab_d[b]      = stab_q[b];
            hold_d[b]      = hold_q[b];
            rep_d[b]       = rep_q[b];
            post_s[b]      = 1'b0;
            post_type_s[b] = EVT_PRESS;
            if (tick_s) begin
                if (sync2_q[b] == level_q[b]) begin
                    stab_d[b] = {SW{1'b0}};
                end else if (stab_q[b] == SW'(STABLE_TICKS - 1)) begin
                    stab_d[b]      = {SW{1'b0}};
                    level_d[b]     = ~level_q[b];
                    post_s[b]      = 1'b1;
                    post_type_s[b] = level_q[b] ? EVT_RELEASE : EVT_PRESS;
                end else begin
                    stab_d[b] = stab_q[b] + SW'(1);
                end

                // A falling level wins over any LONG/REPEAT due on the same tick,
                // so RELEASE is never lost.
                if (level_q[b] && !level_d[b]) begin
                    hold_d[b] = {HW{1'b0}};
                    rep_d[b]  = {RW{1'b0}};
                end else if (level_q[b]) begin
                    // Saturate rather than wrap so a very long hold cannot
                    // pass LONG_TICKS a second time.
                    if (hold_q[b] == {HW{1'b1}}) begin
                        hold_d[b] = hold_q[b];
                    end else begin
                        hold_d[b] = hold_q[b] + HW'(1);
                    end
                    if (hold_d[b] == HW'(LONG_TICKS)) begin
                        rep_d[b]       = {RW{1'b0}};
                        post_s[b]      = 1'b1;
                        post_type_s[b] = EVT_LONG;
                    end else if (hold_q[b] >= HW'(LONG_TICKS)) begin
                        if (rep_q[b] == RW'(REPEAT_TICKS - 1)) begin
                            rep_d[b]       = {RW{1'b0}};
                            post_s[b]      = 1'b1;
                            post_type_s[b] = EVT_REPEAT;
                        end else begin
                            rep_d[b] = rep_q[b] + RW'(1);
                        end
                    end else begin
                        rep_d[b] = {RW{1'b0}};
                    end
                end else begin
                    hold_d[b] = {HW{1'b0}};
                    rep_d[b]  = {RW{1'b0}};
                end
            end else begin
                stab_d[b] = stab_q[b];
            end
        end
    end

    // Round-robin search for the first pending slot after the last winner
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = {BW{1'b0}};
        for (int k = 1; k <= N_BTN; k++) begin
            if (!win_found_s && slot_v_q[rr_idx(ptr_q, k)]) begin
                win_found_s = 1'b1;
                win_idx_s   = rr_idx(ptr_q, k);
            end else begin
                win_found_s = win_found_s;
            end
        end
        for (int b = 0; b < N_BTN; b++) begin
            grant_s[b] = load_s && win_found_s && (win_idx_s == BW'(b));
        end
    end

    // Pending slots, overflow flag and the registered event port
    always_comb begin
        slot_v_d    = slot_v_q;
        overflow_d  = overflow_q;
        evt_valid_d = evt_valid_q;
        evt_btn_d   = evt_btn_q;
        evt_type_d  = evt_type_q;
        ptr_d       = ptr_q;
        for (int b = 0; b < N_BTN; b++) begin
            slot_t_d[b] = slot_t_q[b];
            if (post_s[b]) begin
                // A slot being granted this cycle is free for the new event.
                if (slot_v_q[b] && !grant_s[b]) begin
                    overflow_d = 1'b1;
                end else begin
                    slot_v_d[b] = 1'b1;
                    slot_t_d[b] = post_type_s[b];
                end
            end else if (grant_s[b]) begin
                slot_v_d[b] = 1'b0;
            end else begin
                slot_v_d[b] = slot_v_q[b];
            end
        end
        if (load_s) begin
            if (win_found_s) begin
                evt_valid_d = 1'b1;
                evt_btn_d   = win_idx_s;
                evt_type_d  = slot_t_q[win_idx_s];
                ptr_d       = win_idx_s;
            end else begin
                evt_valid_d = 1'b0;
            end
        end else begin
            evt_valid_d = evt_valid_q;
        end
    end

    // State register with synchronous active-low reset
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            presc_q     <= {PW{1'b0}};
            sync1_q     <= {N_BTN{1'b0}};
            sync2_q     <= {N_BTN{1'b0}};
            level_q     <= {N_BTN{1'b0}};
            slot_v_q    <= {N_BTN{1'b0}};
            ptr_q       <= BW'(N_BTN - 1);
            evt_valid_q <= 1'b0;
            evt_btn_q   <= {BW{1'b0}};
            evt_type_q  <= 2'b00;
            overflow_q  <= 1'b0;
            for (int b = 0; b < N_BTN; b++) begin
                stab_q[b]   <= {SW{1'b0}};
                hold_q[b]   <= {HW{1'b0}};
                rep_q[b]    <= {RW{1'b0}};
                slot_t_q[b] <= 2'b00;
            end
        end else begin
            presc_q     <= presc_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            level_q     <= level_d;
            slot_v_q    <= slot_v_d;
            ptr_q       <= ptr_d;
            evt_valid_q <= evt_valid_d;
            evt_btn_q   <= evt_btn_d;
            evt_type_q  <= evt_type_d;
            overflow_q  <= overflow_d;
            for (int b = 0; b < N_BTN; b++) begin
                stab_q[b]   <= stab_d[b];
                hold_q[b]   <= hold_d[b];
                rep_q[b]    <= rep_d[b];
                slot_t_q[b] <= slot_t_d[b];
            end
        end
    end

    assign o_evt_valid = evt_valid_q;
    assign o_evt_btn   = evt_btn_q;
    assign o_evt_type  = evt_type_q;
    assign o_btn_level = level_q;
    assign o_overflow  = overflow_q;

endmodule

// File: tb/tb_btn_event_controller.sv
// -----------------------------------------------------------------------------
// Testbench for btn_event_controller (TICK_DIV=4, STABLE_TICKS=3,
// LONG_TICKS=10, REPEAT_TICKS=4, N_BTN=4). Expected events are queued when the
// stimulus is applied and compared in order as the DUT hands them over.
// Inputs change one cycle after reset release or right after a tick edge, so
// each change is seen by the next prescaler tick.
// -----------------------------------------------------------------------------
module tb_btn_event_controller;

    localparam int N_BTN = 4;
    localparam int TDIV  = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] btn;
    logic       ready;
    logic       valid;
    logic [1:0] ebtn;
    logic [1:0] etype;
    logic [3:0] lvl;
    logic       ovf;

    int checks = 0;
    int errors = 0;

    // Each entry is {btn[1:0], type[1:0]}
    logic [3:0] exp_q [$];

    typedef struct {
        logic [3:0]  btn;
        int          ticks;
        logic [3:0]  lvl;
        int          n;
        logic [47:0] ev;   // events, first one in the lowest nibble
    } vec_t;

    vec_t tbl [12];

    always #5 clk = ~clk;

    btn_event_controller #(
        .N_BTN(N_BTN), .TICK_DIV(TDIV), .STABLE_TICKS(3),
        .LONG_TICKS(10), .REPEAT_TICKS(4)
    ) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_btn(btn),
        .o_evt_valid(valid), .i_evt_ready(ready),
        .o_evt_btn(ebtn), .o_evt_type(etype),
        .o_btn_level(lvl), .o_overflow(ovf)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: scoreboard at the falling edge, then return 1 unit after the rising edge.
    task automatic cycle();
        logic [3:0] e;
        @(negedge clk);
        if (valid && ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL evt_unexpected got btn=%0d type=%0d expected none", ebtn, etype);
            end else begin
                e = exp_q.pop_front();
                if ({ebtn, etype} !== e) begin
                    errors++;
                    $display("FAIL evt_seq got btn=%0d type=%0d expected btn=%0d type=%0d",
                             ebtn, etype, e[3:2], e[1:0]);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic push(input int b, input int t);
        exp_q.push_back({2'(b), 2'(t)});
    endtask

    initial begin
        // btn, ticks, level after, #events, events
        tbl[0]  = '{4'b0010,  2, 4'b0000, 0, 48'h0};           // glitch on btn1
        tbl[1]  = '{4'b0000,  2, 4'b0000, 0, 48'h0};
        tbl[2]  = '{4'b1111,  3, 4'b1111, 4, 48'hC840};        // P0 P1 P2 P3
        tbl[3]  = '{4'b0000,  3, 4'b0000, 4, 48'hD951};        // R0 R1 R2 R3
        tbl[4]  = '{4'b0010,  3, 4'b0010, 1, 48'h4};           // P1 -> pointer 1
        tbl[5]  = '{4'b0000,  3, 4'b0000, 1, 48'h5};           // R1
        tbl[6]  = '{4'b1111,  3, 4'b1111, 4, 48'h40C8};        // P2 P3 P0 P1
        tbl[7]  = '{4'b0000,  3, 4'b0000, 4, 48'h51D9};        // R2 R3 R0 R1
        tbl[8]  = '{4'b0100, 22, 4'b0100, 4, 48'hBBA8};        // P2 L2 Rp2 Rp2
        tbl[9]  = '{4'b0000,  3, 4'b0000, 1, 48'h9};           // R2 (beats the due REPEAT)
        tbl[10] = '{4'b0001, 45, 4'b0001, 10, 48'h3333333320}; // P0 L0 Rp0 x8, hold saturates
        tbl[11] = '{4'b0000,  3, 4'b0000, 1, 48'h1};           // R0

        rst_n = 1'b0;
        btn   = 4'b0000;
        ready = 1'b0;
        run(3);
        rst_n = 1'b1;
        chk("rst_valid", int'(valid), 0);
        chk("rst_btn", int'(ebtn), 0);
        chk("rst_type", int'(etype), 0);
        chk("rst_level", int'(lvl), 0);
        chk("rst_ovf", int'(ovf), 0);
        ready = 1'b1;

        for (int i = 0; i < 12; i++) begin
            btn = tbl[i].btn;
            for (int j = 0; j < tbl[i].n; j++) begin
                exp_q.push_back(4'(tbl[i].ev >> (4 * j)));
            end
            run(tbl[i].ticks * TDIV);
            chk($sformatf("tbl%0d_level", i), int'(lvl), int'(tbl[i].lvl));
        end

        // Exact latency: PRESS posted on tick T, level at T+1, port at T+2
        btn = 4'b0001;
        push(0, 0);
        run(11);
        run(1);
        chk("lat_level_t1", int'(lvl), 'h1);
        chk("lat_valid_t1", int'(valid), 0);
        run(1);
        chk("lat_valid_t2", int'(valid), 1);
        chk("lat_btn_t2", int'(ebtn), 0);
        chk("lat_type_t2", int'(etype), 0);
        run(1);
        chk("lat_valid_t3", int'(valid), 0);
        run(2);
        btn = 4'b0000;
        push(0, 1);
        run(12);
        run(4);

        // Back-pressure: PRESS held, RELEASE waits in slot, second PRESS dropped
        ready = 1'b0;
        push(3, 0);
        push(3, 1);
        btn = 4'b1000;
        run(12);
        btn = 4'b0000;
        run(12);
        chk("bp_valid", int'(valid), 1);
        chk("bp_btn", int'(ebtn), 3);
        chk("bp_type", int'(etype), 0);
        chk("bp_ovf0", int'(ovf), 0);
        btn = 4'b1000;
        run(12);
        chk("ovf_set", int'(ovf), 1);
        chk("ovf_held_btn", int'(ebtn), 3);
        chk("ovf_held_type", int'(etype), 0);
        chk("ovf_level", int'(lvl), 'h8);
        ready = 1'b1;
        run(4);
        chk("bp_drained", int'(valid), 0);

        // Reset while an event is presented
        ready = 1'b0;
        btn   = 4'b0000;
        run(13);
        chk("pre_rst_valid", int'(valid), 1);
        chk("pre_rst_type", int'(etype), 1);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        chk("rst2_valid", int'(valid), 0);
        chk("rst2_btn", int'(ebtn), 0);
        chk("rst2_type", int'(etype), 0);
        chk("rst2_level", int'(lvl), 0);
        chk("rst2_ovf", int'(ovf), 0);
        ready = 1'b1;
        run(12);

        // Grant and post to the same slot in one cycle: no overflow
        ready = 1'b0;
        push(1, 0);
        btn = 4'b0010;
        run(12);
        push(1, 1);
        btn = 4'b0000;
        run(12);
        chk("gp_ovf_before", int'(ovf), 0);
        push(1, 0);
        btn = 4'b0010;
        run(11);
        ready = 1'b1;
        run(1);
        chk("gp_no_ovf", int'(ovf), 0);
        run(4);
        chk("gp_valid_end", int'(valid), 0);
        chk("gp_level", int'(lvl), 'h2);
        chk("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
